// File: rtl/gemv_scheduler.sv
// gemv_scheduler: round-robin arbiter sharing one GEMV engine between
// NUM_REQ requesters. Latches the winner's dimensions, pulses the engine
// start, guards the run with a watchdog and returns a done/err pulse.
module gemv_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIM_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIM_W-1:0] req_rows,
  input  logic [NUM_REQ*DIM_W-1:0] req_cols,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_err,
  output logic                     eng_start,
  output logic [DIM_W-1:0]         eng_rows,
  output logic [DIM_W-1:0]         eng_cols,
  output logic                     eng_abort,
  input  logic                     eng_done,
  output logic                     busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic [WD_W-1:0] wdog;
  logic            res_ok, res_ok_nx;
  logic            dim_zero;

  assign busy     = (state != S_IDLE);
  // Grant follows the latched winner for the whole job; zero in IDLE.
  assign grant    = busy ? (NUM_REQ'(1) << id_q) : '0;
  assign dim_zero = (eng_rows == '0) || (eng_cols == '0);

  // Round-robin pick: first pending request scanning upward from rr_ptr.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NR);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and pulse outputs; eng_done outside WAIT is ignored.
  always_comb begin
    state_nx  = state;
    res_ok_nx = res_ok;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    req_done  = '0;
    req_err   = '0;
    case (state)
      S_IDLE: begin
        if (win_vld) state_nx = S_START;
      end
      S_START: begin
        if (dim_zero) begin
          state_nx  = S_RESP;
          res_ok_nx = 1'b1;
        end else begin
          eng_start = 1'b1;
          state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          state_nx  = S_RESP;
          res_ok_nx = 1'b1;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          eng_abort = 1'b1;
          state_nx  = S_RESP;
          res_ok_nx = 1'b0;
        end
      end
      S_RESP: begin
        if (res_ok) req_done = grant;
        else        req_err  = grant;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job context: winner id, latched dimensions, watchdog, rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      rr_ptr   <= '0;
      wdog     <= '0;
      res_ok   <= 1'b0;
      eng_rows <= '0;
      eng_cols <= '0;
    end else begin
      res_ok <= res_ok_nx;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            id_q     <= win_id;
            eng_rows <= req_rows[win_id*DIM_W +: DIM_W];
            eng_cols <= req_cols[win_id*DIM_W +: DIM_W];
          end
        end
        S_START: wdog <= '0;
        S_WAIT:  wdog <= wdog + 1'b1;
        S_RESP:  rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gemv_scheduler.sv
// Directed bench for gemv_scheduler: expected jobs are queued when a request
// is raised and retired against the DUT's grant/start/response activity.
module tb_gemv_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_rows, req_cols;
  logic [N-1:0]  grant, req_done, req_err;
  logic          eng_start, eng_abort, eng_done, busy;
  logic [DW-1:0] eng_rows, eng_cols;

  typedef struct {
    logic [N-1:0]  g;
    logic [DW-1:0] r;
    logic [DW-1:0] c;
    logic [N-1:0]  d;
    logic [N-1:0]  e;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  gemv_scheduler #(.NUM_REQ(N), .DIM_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rows(req_rows), .req_cols(req_cols),
    .grant(grant), .req_done(req_done), .req_err(req_err),
    .eng_start(eng_start), .eng_rows(eng_rows), .eng_cols(eng_cols),
    .eng_abort(eng_abort), .eng_done(eng_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    n_cmp++;
    n_mis++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_dims(input int i, input logic [DW-1:0] r, input logic [DW-1:0] c);
    req_rows[i*DW +: DW] = r;
    req_cols[i*DW +: DW] = c;
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic [DW-1:0] r,
                          input logic [DW-1:0] c, input logic [N-1:0] d,
                          input logic [N-1:0] e);
    exp_t x;
    x.g = g; x.r = r; x.c = c; x.d = d; x.e = e;
    sbq.push_back(x);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Waits for the START cycle and checks grant/dimensions/start pulse.
  task automatic start_phase(input bit hold_done, output int waited);
    exp_t e;
    waited = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      eng_done = hold_done;
      samp();
      if (grant != '0) begin
        waited = i;
        break;
      end
    end
    eng_done = 1'b0;
    if (waited < 0 || sbq.size() == 0) begin
      expire("start_seen");
      return;
    end
    e = sbq[0];
    chk("grant",     32'(grant),     32'(e.g));
    chk("eng_rows",  32'(eng_rows),  32'(e.r));
    chk("eng_cols",  32'(eng_cols),  32'(e.c));
    chk("eng_start", 32'(eng_start), 32'((e.r != '0) && (e.c != '0)));
    chk("busy",      32'(busy),      32'd1);
  endtask

  // Plays the engine (eng_done on WAIT cycle done_at) and retires the response.
  task automatic resp_phase(input int done_at, input int limit, output int resp_w,
                            output int n_abort, output int abort_w, output int n_start);
    exp_t e;
    resp_w = -1; n_abort = 0; abort_w = -1; n_start = 0;
    for (int w = 1; w <= limit; w++) begin
      tick();
      eng_done = (w == done_at);
      samp();
      if (eng_abort) begin
        n_abort++;
        if (abort_w < 0) abort_w = w;
      end
      if (eng_start) n_start++;
      if ((req_done | req_err) != '0) begin
        resp_w = w;
        break;
      end
    end
    eng_done = 1'b0;
    if (resp_w < 0 || sbq.size() == 0) begin
      expire("resp_seen");
      return;
    end
    e = sbq.pop_front();
    chk("req_done",   32'(req_done), 32'(e.d));
    chk("req_err",    32'(req_err),  32'(e.e));
    chk("grant_resp", 32'(grant),    32'(e.g));
  endtask

  task automatic after_resp(input string tag);
    tick();
    samp();
    chk({tag, "_busy"},  32'(busy),               32'd0);
    chk({tag, "_grant"}, 32'(grant),              32'd0);
    chk({tag, "_pulse"}, 32'(req_done | req_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int w, rw, na, aw, ns, pulses;
    rst = 1'b1; req = '0; req_rows = '0; req_cols = '0; eng_done = 1'b0;

    // Reset state
    repeat (3) tick();
    samp();
    chk("rst_grant",     32'(grant),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_start",     32'(eng_start), 32'd0);
    chk("rst_abort",     32'(eng_abort), 32'd0);
    chk("rst_done",      32'(req_done),  32'd0);
    chk("rst_err",       32'(req_err),   32'd0);
    chk("rst_rows",      32'(eng_rows),  32'd0);
    chk("rst_cols",      32'(eng_cols),  32'd0);
    tick();
    rst = 1'b0;

    // Single job, requester 1, engine done 10 cycles after start
    req = 4'b0010;
    set_dims(1, 8'd16, 8'd32);
    push_exp(4'b0010, 8'd16, 8'd32, 4'b0010, 4'b0000);
    samp();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    start_phase(1'b0, w);
    chk("t1_latency", 32'(w), 32'd1);
    set_dims(1, 8'd99, 8'd77);
    resp_phase(10, 30, rw, na, aw, ns);
    chk("t1_resp_w",  32'(rw), 32'd11);
    chk("t1_abort",   32'(na), 32'd0);
    chk("t1_restart", 32'(ns), 32'd0);
    req = '0;
    after_resp("t1_after");
    chk("t1_rows_hold", 32'(eng_rows), 32'd16);
    chk("t1_cols_hold", 32'(eng_cols), 32'd32);

    // Spurious eng_done in IDLE
    tick();
    eng_done = 1'b1;
    samp();
    tick();
    eng_done = 1'b0;
    samp();
    chk("idle_spurious_busy", 32'(busy), 32'd0);

    // Fairness: all four requesting continuously
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_dims(i, 8'(10 + i), 8'(20 + i));
    for (int j = 0; j < 5; j++) begin
      logic [N-1:0] g;
      g = N'(1 << (j % N));
      push_exp(g, 8'(10 + j % N), 8'(20 + j % N), g, 4'b0000);
    end
    for (int j = 0; j < 5; j++) begin
      start_phase(1'b0, w);
      chk(j == 0 ? "fair_latency" : "fair_rearb_gap", 32'(w), j == 0 ? 32'd1 : 32'd2);
      resp_phase(3, 10, rw, na, aw, ns);
      chk("fair_resp_w", 32'(rw), 32'd4);
      if (j == 4) req = '0;
    end
    after_resp("fair_after");

    // Timeout on requester 0
    do_reset();
    req = 4'b0001;
    set_dims(0, 8'd5, 8'd7);
    push_exp(4'b0001, 8'd5, 8'd7, 4'b0000, 4'b0001);
    start_phase(1'b0, w);
    resp_phase(-1, 24, rw, na, aw, ns);
    chk("to_abort_w", 32'(aw), 32'd16);
    chk("to_abort_n", 32'(na), 32'd1);
    chk("to_resp_w",  32'(rw), 32'd17);
    req = '0;
    after_resp("to_after");

    // Engine done one cycle before the limit
    tick();
    req = 4'b0010;
    set_dims(1, 8'd3, 8'd4);
    push_exp(4'b0010, 8'd3, 8'd4, 4'b0010, 4'b0000);
    start_phase(1'b0, w);
    resp_phase(15, 24, rw, na, aw, ns);
    chk("late_resp_w", 32'(rw), 32'd16);
    chk("late_abort",  32'(na), 32'd0);
    req = '0;
    after_resp("late_after");

    // Engine done on the watchdog-limit cycle wins over timeout
    tick();
    req = 4'b0100;
    set_dims(2, 8'd1, 8'd1);
    push_exp(4'b0100, 8'd1, 8'd1, 4'b0100, 4'b0000);
    start_phase(1'b0, w);
    resp_phase(16, 24, rw, na, aw, ns);
    chk("edge_resp_w", 32'(rw), 32'd17);
    chk("edge_abort",  32'(na), 32'd0);
    req = '0;
    after_resp("edge_after");

    // eng_done during IDLE-with-request and START is ignored (rr_ptr=3 -> 0001)
    tick();
    req = 4'b0001;
    eng_done = 1'b1;
    set_dims(0, 8'd2, 8'd2);
    push_exp(4'b0001, 8'd2, 8'd2, 4'b0001, 4'b0000);
    start_phase(1'b1, w);
    chk("sp_latency", 32'(w), 32'd1);
    resp_phase(4, 12, rw, na, aw, ns);
    chk("sp_resp_w", 32'(rw), 32'd5);
    req = '0;
    after_resp("sp_after");

    // Zero dimension skips the engine
    tick();
    req = 4'b0100;
    set_dims(2, 8'd0, 8'd8);
    push_exp(4'b0100, 8'd0, 8'd8, 4'b0100, 4'b0000);
    start_phase(1'b0, w);
    chk("zd_latency", 32'(w), 32'd1);
    resp_phase(-1, 4, rw, na, aw, ns);
    chk("zd_resp_w", 32'(rw), 32'd1);
    req = '0;
    after_resp("zd_after");

    // rr_ptr now 3: 1001 picks requester 3; reset it mid-WAIT
    tick();
    req = 4'b1001;
    set_dims(3, 8'd9, 8'd9);
    set_dims(0, 8'd6, 8'd6);
    push_exp(4'b1000, 8'd9, 8'd9, 4'b1000, 4'b0000);
    start_phase(1'b0, w);
    tick();
    tick();
    tick();
    rst = 1'b1;
    samp();
    tick();
    rst = 1'b0;
    req = '0;
    samp();
    chk("mr_grant", 32'(grant),     32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_start", 32'(eng_start), 32'd0);
    chk("mr_abort", 32'(eng_abort), 32'd0);
    chk("mr_done",  32'(req_done),  32'd0);
    chk("mr_err",   32'(req_err),   32'd0);
    chk("mr_rows",  32'(eng_rows),  32'd0);
    chk("mr_cols",  32'(eng_cols),  32'd0);
    void'(sbq.pop_front());
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      samp();
      if ((req_done | req_err) != '0) pulses++;
    end
    chk("mr_no_pulse", 32'(pulses), 32'd0);

    // After reset, rr_ptr=0: 1001 picks requester 0
    tick();
    req = 4'b1001;
    push_exp(4'b0001, 8'd6, 8'd6, 4'b0001, 4'b0000);
    start_phase(1'b0, w);
    resp_phase(2, 10, rw, na, aw, ns);
    chk("pr_resp_w", 32'(rw), 32'd3);
    req = '0;
    after_resp("pr_after");

    chk("sbq_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
